// File: rtl/clk_period_meter_if.sv
// Bundle of clk_period_meter measurement signals; master drives meas_clk/enable, slave is the meter.
// CLK_PERIOD_METER_MINMAX_EN adds minmax_clr, min_period and max_period.
interface clk_period_meter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             meas_clk;
   logic             enable;
   logic [WIDTH-1:0] half_period;
   logic             meas_valid;
   logic             locked;
   logic             timeout;
`ifdef CLK_PERIOD_METER_MINMAX_EN
   logic             minmax_clr;
   logic [WIDTH-1:0] min_period;
   logic [WIDTH-1:0] max_period;

   modport master (
      output meas_clk, enable, minmax_clr,
      input  half_period, meas_valid, locked, timeout, min_period, max_period
   );
   modport slave (
      input  meas_clk, enable, minmax_clr,
      output half_period, meas_valid, locked, timeout, min_period, max_period
   );
`else
   modport master (
      output meas_clk, enable,
      input  half_period, meas_valid, locked, timeout
   );
   modport slave (
      input  meas_clk, enable,
      output half_period, meas_valid, locked, timeout
   );
`endif
endinterface

// File: rtl/clk_period_meter.sv
// Measures the half-period of an asynchronous toggling clock in inclk cycles, with lock and loss detection.
// Optional min/max tracking is enabled by defining CLK_PERIOD_METER_MINMAX_EN.
module clk_period_meter #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned TIMEOUT     = 1048576,
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic               inclk,
   input logic               Reset_n,
   clk_period_meter_if.slave bus
);

   localparam int unsigned      MW       = $clog2(LOCK_COUNT + 1);
   localparam logic [WIDTH-1:0] C_TMO    = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] C_TMO_M1 = WIDTH'(TIMEOUT - 1);
   localparam logic [MW-1:0]    C_LOCK   = MW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEASURE,
      S_LOST
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [WIDTH-1:0]       r_cnt;
   logic [WIDTH-1:0]       r_half_period;
   logic                   r_valid;
   logic                   r_locked;
   logic                   r_timeout;
   logic [MW-1:0]          r_match_cnt;

   logic                   w_edge;
   logic [WIDTH:0]         w_diff;
   logic                   w_close;
   logic [MW-1:0]          w_match_next;

   always_ff @(posedge inclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.meas_clk};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_edge = r_sync[SYNC_STAGES-1] ^ r_prev;

   always_ff @(posedge inclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt <= '0;
      end else if (w_edge) begin
         r_cnt <= WIDTH'(1);
      end else if (r_cnt != C_TMO) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   // One extra bit keeps the signed difference exact; -1 is all ones.
   assign w_diff  = {1'b0, r_cnt} - {1'b0, r_half_period};
   assign w_close = (w_diff == '0) || (w_diff == (WIDTH+1)'(1)) || (w_diff == '1);

   always_comb begin
      w_match_next = MW'(1);
      if ((r_match_cnt != '0) && w_close) begin
         w_match_next = (r_match_cnt == C_LOCK) ? C_LOCK : r_match_cnt + MW'(1);
      end
   end

   always_ff @(posedge inclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= S_IDLE;
         r_half_period <= '0;
         r_valid       <= 1'b0;
         r_locked      <= 1'b0;
         r_timeout     <= 1'b0;
         r_match_cnt   <= '0;
      end else begin
         r_valid <= 1'b0;
         if (!bus.enable) begin
            r_state     <= S_IDLE;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_match_cnt <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_edge) r_state <= S_MEASURE;
               end
               S_MEASURE: begin
                  // An edge on the timeout cycle still counts as a measurement.
                  if (w_edge) begin
                     r_half_period <= r_cnt;
                     r_valid       <= 1'b1;
                     r_match_cnt   <= w_match_next;
                     r_locked      <= (w_match_next == C_LOCK);
                  end else if (r_cnt >= C_TMO_M1) begin
                     r_state     <= S_LOST;
                     r_timeout   <= 1'b1;
                     r_locked    <= 1'b0;
                     r_match_cnt <= '0;
                  end
               end
               S_LOST: begin
                  if (w_edge) begin
                     r_state   <= S_MEASURE;
                     r_timeout <= 1'b0;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.half_period = r_half_period;
   assign bus.meas_valid  = r_valid;
   assign bus.locked      = r_locked;
   assign bus.timeout     = r_timeout;

`ifdef CLK_PERIOD_METER_MINMAX_EN
   logic [WIDTH-1:0] r_min;
   logic [WIDTH-1:0] r_max;

   always_ff @(posedge inclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_min <= '1;
         r_max <= '0;
      end else if (bus.minmax_clr) begin
         r_min <= r_valid ? r_half_period : '1;
         r_max <= r_valid ? r_half_period : '0;
      end else if (r_valid) begin
         if (r_half_period < r_min) r_min <= r_half_period;
         if (r_half_period > r_max) r_max <= r_half_period;
      end
   end

   assign bus.min_period = r_min;
   assign bus.max_period = r_max;
`endif

endmodule
